dc_ramp_cal: RTL and testbench

DC_RAMP_CAL -- requirements
Module: dc_ramp_cal

---
 rtl/dc_ramp_cal.sv | 145 ++++++++++++++
 tb/tb_dc_ramp_cal.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/dc_ramp_cal.sv
// rtl/dc_ramp_cal.sv - per-channel DC level ramp with slope/intercept DAC calibration
// Optional macro DC_RAMP_SLEW_EN enables rate-limited level slewing.
module dc_ramp_cal #(
    parameter int NCH       = 2,
    parameter int IN_W      = 16,
    parameter int DAC_W     = 12,
    parameter int PRE_SHIFT = 3,
    parameter int CAL_SCALE = 11,
    parameter int RAMP_STEP = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sample_tick,
    input  logic [NCH-1:0]         en,
    input  logic [NCH*IN_W-1:0]    dc_ofs,
    input  logic [NCH*16-1:0]      slope,
    input  logic [NCH*DAC_W-1:0]   intercept,
    output logic [NCH*DAC_W-1:0]   dac_word,
    output logic                   out_valid,
    output logic [NCH-1:0]         sat,
    output logic [NCH-1:0]         settled
);
    localparam int PW = (IN_W + 16 > 32) ? IN_W + 16 : 32;
    localparam int SW = PW + 2;
    localparam logic signed [SW-1:0] L_MID   = SW'(2 ** (DAC_W - 1));
    localparam logic signed [SW-1:0] L_MAX   = SW'(2 ** DAC_W - 1);
    localparam logic [DAC_W-1:0]     L_MID_W = DAC_W'(2 ** (DAC_W - 1));

    if (RAMP_STEP < 1) begin : g_bad_ramp_step
        $error("RAMP_STEP must be positive");
    end

    // Pipeline valid chain shared by all channels; out_valid fires regardless of en.
    logic r_v1;
    logic r_v2;
    logic r_out_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1        <= 1'b0;
            r_v2        <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_v1        <= sample_tick;
            r_v2        <= r_v1;
            r_out_valid <= r_v2;
        end
    end

    assign out_valid = r_out_valid;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic signed [IN_W-1:0]  r_level;
        logic                    r_settled;
        logic                    r_en1;
        logic                    r_en2;
        logic signed [PW-1:0]    r_prod;
        logic [DAC_W-1:0]        r_dac;
        logic                    r_sat;

        logic signed [IN_W-1:0]  w_target;
        logic signed [IN_W-1:0]  w_level_nxt;
        logic signed [IN_W-1:0]  w_pre;
        logic signed [15:0]      w_slope;
        logic signed [DAC_W-1:0] w_icpt;
        logic signed [PW-1:0]    w_prod;
        logic signed [SW-1:0]    w_word;
        logic [DAC_W-1:0]        w_dac;
        logic                    w_clamp;

        assign w_target = dc_ofs[g*IN_W +: IN_W];
        assign w_slope  = slope[g*16 +: 16];
        assign w_icpt   = intercept[g*DAC_W +: DAC_W];

`ifdef DC_RAMP_SLEW_EN
        localparam logic signed [IN_W:0] L_STEP = (IN_W + 1)'(RAMP_STEP);
        logic signed [IN_W:0] w_diff;

        // One extra bit keeps target - level from wrapping at full-scale swings.
        assign w_diff = {w_target[IN_W-1], w_target} - {r_level[IN_W-1], r_level};

        always_comb begin
            w_level_nxt = w_target;
            if (w_diff > L_STEP) begin
                w_level_nxt = r_level + L_STEP[IN_W-1:0];
            end else if (w_diff < -L_STEP) begin
                w_level_nxt = r_level - L_STEP[IN_W-1:0];
            end
        end
`else
        assign w_level_nxt = w_target;
`endif

        assign w_pre  = r_level >>> PRE_SHIFT;
        assign w_prod = PW'(w_pre) * PW'(w_slope);

        // Arithmetic shift gives floor rounding for negative products.
        assign w_word = (SW'(r_prod) >>> CAL_SCALE) + SW'(w_icpt) + L_MID;

        always_comb begin
            w_dac   = w_word[DAC_W-1:0];
            w_clamp = 1'b0;
            if (w_word[SW-1]) begin
                w_dac   = '0;
                w_clamp = 1'b1;
            end else if (w_word > L_MAX) begin
                w_dac   = '1;
                w_clamp = 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_level   <= '0;
                r_settled <= 1'b1;
                r_en1     <= 1'b0;
                r_en2     <= 1'b0;
                r_prod    <= '0;
                r_dac     <= L_MID_W;
                r_sat     <= 1'b0;
            end else begin
                if (sample_tick) begin
                    r_en1 <= en[g];
                    if (en[g]) begin
                        r_level   <= w_level_nxt;
                        r_settled <= (w_level_nxt == w_target);
                    end
                end
                if (r_v1) begin
                    r_en2  <= r_en1;
                    r_prod <= w_prod;
                end
                if (r_v2 && r_en2) begin
                    r_dac <= w_dac;
                    r_sat <= w_clamp;
                end
            end
        end

        assign dac_word[g*DAC_W +: DAC_W] = r_dac;
        assign sat[g]                     = r_sat;
        assign settled[g]                 = r_settled;
    end

endmodule

// File: tb/tb_dc_ramp_cal.sv
// tb/tb_dc_ramp_cal.sv - directed self-checking bench for dc_ramp_cal
// Exercises the slew build when DC_RAMP_SLEW_EN is defined, else the direct build.
module tb_dc_ramp_cal;
    logic        clk = 1'b0;
    logic        rst;
    logic        sample_tick;
    logic [1:0]  en;
    logic [31:0] dc_ofs;
    logic [31:0] slope;
    logic [23:0] intercept;
    logic [23:0] dac_word;
    logic        out_valid;
    logic [1:0]  sat;
    logic [1:0]  settled;

    int n_vec = 0;
    int n_bad = 0;
    int lvl;
    int ov_cnt;

    always #5 clk = ~clk;

    dc_ramp_cal dut (
        .clk         (clk),
        .rst         (rst),
        .sample_tick (sample_tick),
        .en          (en),
        .dc_ofs      (dc_ofs),
        .slope       (slope),
        .intercept   (intercept),
        .dac_word    (dac_word),
        .out_valid   (out_valid),
        .sat         (sat),
        .settled     (settled)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] dac_ch(input int c);
        return 32'(dac_word[c*12 +: 12]);
    endfunction

    function automatic int model_word(input int level);
        int p;
        int w;
        p = (level >>> 3) * 1961;
        w = (p >>> 11) + 24 + 2048;
        if (w < 0) return 0;
        if (w > 4095) return 4095;
        return w;
    endfunction

    // Leaves the bench at the negedge after the third edge, where out_valid must be high.
    task automatic tick(input int d0, input int d1, input logic [1:0] e);
        @(negedge clk);
        check("ov_idle", 32'(out_valid), 0);
        dc_ofs      = {16'(d1), 16'(d0)};
        en          = e;
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        @(negedge clk);
        check("ov_e1", 32'(out_valid), 0);
        @(negedge clk);
        check("ov_e2", 32'(out_valid), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst         = 1'b1;
        sample_tick = 1'b0;
        en          = 2'b00;
        dc_ofs      = '0;
        slope       = {16'd1961, 16'd1961};
        intercept   = {12'd24, 12'd24};
        repeat (3) @(negedge clk);
        check("rst_dac0", dac_ch(0), 2048);
        check("rst_dac1", dac_ch(1), 2048);
        check("rst_ov", 32'(out_valid), 0);
        check("rst_sat", 32'(sat), 0);
        check("rst_settled", 32'(settled), 3);
        rst = 1'b0;

`ifdef DC_RAMP_SLEW_EN
        lvl = 0;
        for (int k = 1; k <= 32; k++) begin
            tick(8000, 8000, 2'b01);
            lvl = (8000 - lvl > 256) ? lvl + 256 : 8000;
            check("slew_dac0", dac_ch(0), 32'(model_word(lvl)));
            check("slew_settled0", 32'(settled[0]), 32'(k == 32));
            check("slew_dac1_hold", dac_ch(1), 2048);
        end
        check("slew_first_word", 32'(model_word(256)), 2102);
        tick(7000, 0, 2'b01);
        check("redirect_dac0", dac_ch(0), 2998);
        check("redirect_settled0", 32'(settled[0]), 0);
`else
        tick(8000, 8000, 2'b01);
        check("pos_dac0", dac_ch(0), 3029);
        check("pos_sat0", 32'(sat[0]), 0);
        check("en01_dac1", dac_ch(1), 2048);
        check("direct_settled", 32'(settled), 3);
        tick(-8000, 0, 2'b01);
        check("neg_dac0", dac_ch(0), 1114);
        check("neg_sat0", 32'(sat[0]), 0);
        tick(32767, 0, 2'b01);
        check("max_dac0", dac_ch(0), 4095);
        check("max_sat0", 32'(sat[0]), 1);
        tick(-32768, 0, 2'b01);
        check("min_dac0", dac_ch(0), 0);
        check("min_sat0", 32'(sat[0]), 1);
        tick(0, -8000, 2'b11);
        check("zero_dac0", dac_ch(0), 2072);
        check("zero_sat0", 32'(sat[0]), 0);
        check("both_dac1", dac_ch(1), 1114);
        tick(32767, 8000, 2'b10);
        check("hold_dac0", dac_ch(0), 2072);
        check("hold_sat0", 32'(sat[0]), 0);
        check("upd_dac1", dac_ch(1), 3029);

        @(negedge clk);
        dc_ofs      = {16'd0, 16'd8000};
        en          = 2'b01;
        sample_tick = 1'b1;
        @(negedge clk);
        dc_ofs      = {16'd0, -16'sd8000};
        @(negedge clk);
        sample_tick = 1'b0;
        @(negedge clk);
        check("b2b_ov_a", 32'(out_valid), 1);
        check("b2b_dac_a", dac_ch(0), 3029);
        @(negedge clk);
        check("b2b_ov_b", 32'(out_valid), 1);
        check("b2b_dac_b", dac_ch(0), 1114);
        @(negedge clk);
        check("b2b_ov_end", 32'(out_valid), 0);
`endif

        @(negedge clk);
        dc_ofs      = {16'd0, 16'd8000};
        en          = 2'b01;
        sample_tick = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        check("flush_ov", 32'(out_valid), 0);
        check("flush_dac0", dac_ch(0), 2048);
        check("flush_dac1", dac_ch(1), 2048);
        check("flush_settled", 32'(settled), 3);
        rst    = 1'b0;
        ov_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) ov_cnt++;
        end
        check("flush_no_ov", 32'(ov_cnt), 0);
        check("flush_dac0_after", dac_ch(0), 2048);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
